// File: rtl/rr_arbiter_16_pkg.sv
// Shared constants and state type for the 16-way round-robin arbiter.
package rr_arb_pkg;
    localparam int N_REQ      = 16;
    localparam int IDX_W      = 4;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the requester bank and the arbiter.
interface rr_arbiter_16_if;
    import rr_arb_pkg::*;

    logic             enable;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (output enable, output req, input gnt, input gnt_idx, input gnt_valid);
    modport slave  (input enable, input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_arbiter_16_onehot_dec4to16_en.sv
// 4-to-16 one-hot decoder with enable; output is all zeros when disabled.
module onehot_dec4to16_en
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] dec
);

    // Decode idx into a single set bit, gated by en
    always_comb begin
        dec = {N_REQ{1'b0}};
        if (en) begin
            dec[idx] = 1'b1;
        end else begin
            dec = {N_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with grant hold until release and a bounded hold time.
module rr_arbiter_16
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_16_if.slave   bus
);

    // A zero HOLD_MAX disables the timeout entirely.
    localparam bit                    HOLD_LIMITED = (HOLD_MAX != 0);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST    =
        HOLD_CNT_W'((HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0);

    arb_state_e            state_r, state_s;
    logic [IDX_W-1:0]      ptr_r, ptr_s;
    logic [IDX_W-1:0]      idx_r, idx_s;
    logic [HOLD_CNT_W-1:0] cnt_r, cnt_s;
    logic [IDX_W:0]        search_s;
    logic                  keep_s;

    // Rotate so ptr lands on bit 0, then take the lowest set bit; MSB of result flags a hit.
    function automatic logic [IDX_W:0] rr_search(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [N_REQ-1:0] rot;
        rot       = N_REQ'({r, r} >> p);
        rr_search = {1'b0, {IDX_W{1'b0}}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rr_search = {1'b1, p + IDX_W'(k)};
            end
        end
    endfunction

    // Next-state, pointer, grantee and hold-counter logic
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        keep_s   = 1'b0;
        search_s = rr_search(bus.req, ptr_r);

        case (state_r)
            ST_IDLE:  keep_s = 1'b0;
            ST_GRANT: keep_s = bus.req[idx_r] && !(HOLD_LIMITED && (cnt_r == HOLD_LAST));
            default:  keep_s = 1'b0;
        endcase

        if (!bus.enable) begin
            state_s = ST_IDLE;
        end else if (keep_s) begin
            state_s = ST_GRANT;
            cnt_s   = (cnt_r == {HOLD_CNT_W{1'b1}}) ? cnt_r : (cnt_r + 8'd1);
        end else if (search_s[IDX_W]) begin
            // Release and fresh grant share this cycle, so handover has no idle gap.
            state_s = ST_GRANT;
            idx_s   = search_s[IDX_W-1:0];
            ptr_s   = search_s[IDX_W-1:0] + 4'd1;
            cnt_s   = 8'd0;
        end else begin
            state_s = ST_IDLE;
        end
    end

    // State, pointer, grantee index and hold counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= 4'd0;
            idx_r   <= 4'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
        end
    end

    assign bus.gnt_idx   = idx_r;
    assign bus.gnt_valid = (state_r == ST_GRANT);

    onehot_dec4to16_en u_dec (
        .idx (idx_r),
        .en  (state_r == ST_GRANT),
        .dec (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus random traffic against a reference model.
module tb_rr_arbiter_16;
    import rr_arb_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [15:0] rq    = 16'h0000;

    int errors = 0;
    int checks = 0;

    rr_arbiter_16_if bus8 ();
    rr_arbiter_16_if bus4 ();

    assign bus8.enable = en;
    assign bus8.req    = rq;
    assign bus4.enable = en;
    assign bus4.req    = rq;

    rr_arbiter_16 #(.HOLD_MAX(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    rr_arbiter_16 #(.HOLD_MAX(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    // Reference model, one slot per DUT: [0] HOLD_MAX=8, [1] HOLD_MAX=4.
    int hmax [2] = '{8, 4};
    bit mv   [2];
    int mi   [2];
    int mp   [2];
    int mh   [2];

    function automatic int rr_find(int p, logic [15:0] r);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic [15:0] exp_gnt(int d);
        logic [15:0] one;
        one = 16'h0001;
        return mv[d] ? (one << mi[d]) : 16'h0000;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mi[d] = 0; mp[d] = 0; mh[d] = 0;
        end
    endtask

    task automatic model_step(int d);
        int w;
        if (!en) begin
            mv[d] = 1'b0;
        end else if (!mv[d] || !rq[mi[d]] || (hmax[d] != 0 && mh[d] == hmax[d])) begin
            w = rr_find(mp[d], rq);
            if (w < 0) begin
                mv[d] = 1'b0;
            end else begin
                mv[d] = 1'b1; mi[d] = w; mp[d] = (w + 1) % 16; mh[d] = 1;
            end
        end else begin
            mh[d]++;
        end
    endtask

    // One clock: model sees the same inputs the DUTs sample, then settle past the edge.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        rq    = 16'h0000;
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus8.gnt !== 16'h0000 || bus8.gnt_valid !== 1'b0 || bus8.gnt_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset: gnt=%h valid=%b idx=%0d, required gnt=0000 valid=0 idx=0",
                     bus8.gnt, bus8.gnt_valid, bus8.gnt_idx);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_grant();
        en = 1'b1;
        rq = 16'h0001;
        tick();
        checks++;
        if (bus8.gnt !== 16'h0001 || bus8.gnt_idx !== 4'd0 || bus8.gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: gnt=%h idx=%0d valid=%b, required gnt=0001 idx=0 valid=1",
                     bus8.gnt, bus8.gnt_idx, bus8.gnt_valid);
        end
    endtask

    task automatic test_hold_rotation();
        int prev;
        int run;
        int order [6] = '{0, 15, 0, 15, 0, 15};
        int g;
        do_reset();
        en = 1'b1;
        rq = 16'h8001;
        prev = -1; run = 0; g = 0;
        for (int c = 0; c < 48; c++) begin
            tick();
            checks++;
            if (bus8.gnt_valid !== 1'b1 || bus8.gnt !== exp_gnt(0)) begin
                errors++;
                $display("FAIL hold_rotation c=%0d: gnt=%h valid=%b, required gnt=%h valid=1",
                         c, bus8.gnt, bus8.gnt_valid, exp_gnt(0));
            end
            if (int'(bus8.gnt_idx) != prev) begin
                if (prev >= 0) begin
                    checks++;
                    if (run != 8) begin
                        errors++;
                        $display("FAIL hold_length: holder %0d held %0d cycles, required 8", prev, run);
                    end
                end
                checks++;
                if (g < 6 && int'(bus8.gnt_idx) != order[g]) begin
                    errors++;
                    $display("FAIL hold_order g=%0d: idx=%0d, required %0d", g, bus8.gnt_idx, order[g]);
                end
                g++;
                prev = int'(bus8.gnt_idx);
                run  = 1;
            end else begin
                run++;
            end
        end
    endtask

    task automatic test_drop_release();
        int order [4] = '{0, 4, 8, 0};
        logic [15:0] dropped;
        logic [15:0] one;
        one = 16'h0001;
        do_reset();
        en = 1'b1;
        rq = 16'h0111;
        dropped = 16'h0000;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                if (c == 0) rq = rq | dropped;
                checks++;
                if (int'(bus8.gnt_idx) != order[g] || bus8.gnt_valid !== 1'b1 ||
                    bus8.gnt !== exp_gnt(0)) begin
                    errors++;
                    $display("FAIL drop_release g=%0d c=%0d: idx=%0d valid=%b gnt=%h, required idx=%0d valid=1 gnt=%h",
                             g, c, bus8.gnt_idx, bus8.gnt_valid, bus8.gnt, order[g], exp_gnt(0));
                end
            end
            dropped = one << order[g];
            rq = rq & ~dropped;
        end
    endtask

    task automatic test_single_timeout();
        do_reset();
        en = 1'b1;
        rq = 16'h0020;
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if (bus4.gnt !== 16'h0020 || bus4.gnt_valid !== 1'b1 || bus4.gnt_idx !== 4'd5) begin
                errors++;
                $display("FAIL single_timeout c=%0d: gnt=%h valid=%b idx=%0d, required gnt=0020 valid=1 idx=5",
                         c, bus4.gnt, bus4.gnt_valid, bus4.gnt_idx);
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b1;
        rq = 16'h0008;
        tick();
        en = 1'b0;
        tick();
        checks++;
        if (bus8.gnt !== 16'h0000 || bus8.gnt_valid !== 1'b0 || bus8.gnt_idx !== 4'd3) begin
            errors++;
            $display("FAIL enable_off: gnt=%h valid=%b idx=%0d, required gnt=0000 valid=0 idx=3",
                     bus8.gnt, bus8.gnt_valid, bus8.gnt_idx);
        end
        en = 1'b1;
        rq = 16'h0009;
        tick();
        checks++;
        if (bus8.gnt !== 16'h0001 || bus8.gnt_idx !== 4'd0 || bus8.gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL enable_wrap: gnt=%h idx=%0d valid=%b, required gnt=0001 idx=0 valid=1",
                     bus8.gnt, bus8.gnt_idx, bus8.gnt_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        rq = 16'h0100;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.gnt !== 16'h0000 || bus8.gnt_valid !== 1'b0 || bus8.gnt_idx !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: gnt=%h valid=%b idx=%0d, required gnt=0000 valid=0 idx=0",
                     bus8.gnt, bus8.gnt_valid, bus8.gnt_idx);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        rq = 16'h0201;
        tick();
        checks++;
        if (bus8.gnt_idx !== 4'd0 || bus8.gnt !== 16'h0001) begin
            errors++;
            $display("FAIL ptr_after_reset: idx=%0d gnt=%h, required idx=0 gnt=0001",
                     bus8.gnt_idx, bus8.gnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 16'h0000;
            en = ($urandom_range(0, 9) != 0);
            tick();
            checks++;
            if (bus8.gnt !== exp_gnt(0) || bus8.gnt_valid !== mv[0] || int'(bus8.gnt_idx) != mi[0]) begin
                errors++;
                $display("FAIL random8 c=%0d: gnt=%h valid=%b idx=%0d, required gnt=%h valid=%b idx=%0d",
                         c, bus8.gnt, bus8.gnt_valid, bus8.gnt_idx, exp_gnt(0), mv[0], mi[0]);
            end
            checks++;
            if (bus4.gnt !== exp_gnt(1) || bus4.gnt_valid !== mv[1] || int'(bus4.gnt_idx) != mi[1]) begin
                errors++;
                $display("FAIL random4 c=%0d: gnt=%h valid=%b idx=%0d, required gnt=%h valid=%b idx=%0d",
                         c, bus4.gnt, bus4.gnt_valid, bus4.gnt_idx, exp_gnt(1), mv[1], mi[1]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_grant();
        test_hold_rotation();
        test_drop_release();
        test_single_timeout();
        test_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
